// File: rtl/dualport_ram_clr.sv
`default_nettype none
// ============================================================================
// dualport_ram_clr : true dual-port byte-enabled RAM with a full zero sweep
// Rev 1.0 - initial release
// ============================================================================

module dualport_ram_clr #(
   parameter int DW   = 16,
   parameter int AW   = 6,
   parameter int RDW  = 0,
   parameter int OREG = 0
) (
   input  logic            C,
   input  logic            nR,
   input  logic            aWR,
   input  logic            bWR,
   input  logic [AW-1:0]   aA,
   input  logic [AW-1:0]   bA,
   input  logic [DW-1:0]   aD,
   input  logic [DW-1:0]   bD,
   input  logic [DW/8-1:0] aBE,
   input  logic [DW/8-1:0] bBE,
   output logic [DW-1:0]   aQ,
   output logic [DW-1:0]   bQ,
   input  logic            CLR,
   output logic            BUSY,
   output logic            COL
);

   localparam int            NB        = DW / 8;
   localparam int            DEPTH     = 1 << AW;
   localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t        state;
   logic [AW-1:0] swp;
   logic          col_pulse;
   logic          access;

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] a_old, b_old, a_merge, b_merge, a_s1, b_s1;

   // A clear request outranks any port access sampled on the same edge.
   assign access = (state == RUN) && !CLR;

   always_ff @(posedge C or negedge nR) begin
      if (!nR) begin
         state     <= CLEAR;
         swp       <= '0;
         col_pulse <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               col_pulse <= 1'b0;
               if (swp == LAST_ADDR) begin
                  state <= RUN;
               end else begin
                  swp <= swp + 1'b1;
               end
            end
            RUN: begin
               col_pulse <= !CLR && aWR && bWR && (aA == bA);
               if (CLR) begin
                  state <= CLEAR;
                  swp   <= '0;
               end
            end
            default: begin
               state     <= CLEAR;
               swp       <= '0;
               col_pulse <= 1'b0;
            end
         endcase
      end
   end

   // Port A is written last so it wins lanes enabled on both ports.
   always_ff @(posedge C) begin
      if (state == CLEAR) begin
         mem[swp] <= '0;
      end else if (!CLR) begin
         for (int i = 0; i < NB; i++) begin
            if (bWR && bBE[i]) mem[bA][8*i +: 8] <= bD[8*i +: 8];
            if (aWR && aBE[i]) mem[aA][8*i +: 8] <= aD[8*i +: 8];
         end
      end
   end

   always_comb begin
      a_old   = mem[aA];
      b_old   = mem[bA];
      a_merge = a_old;
      b_merge = b_old;
      for (int i = 0; i < NB; i++) begin
         if (aBE[i]) a_merge[8*i +: 8] = aD[8*i +: 8];
         if (bBE[i]) b_merge[8*i +: 8] = bD[8*i +: 8];
      end
   end

   // Only a port's own write is visible on its Q; the other port always sees the old word.
   always_ff @(posedge C or negedge nR) begin
      if (!nR) begin
         a_s1 <= '0;
         b_s1 <= '0;
      end else begin
         a_s1 <= !access ? '0 : ((aWR && RDW == 0) ? a_merge : a_old);
         b_s1 <= !access ? '0 : ((bWR && RDW == 0) ? b_merge : b_old);
      end
   end

   generate
      if (OREG != 0) begin : g_oreg
         logic [DW-1:0] a_s2, b_s2;

         always_ff @(posedge C or negedge nR) begin
            if (!nR) begin
               a_s2 <= '0;
               b_s2 <= '0;
            end else begin
               a_s2 <= access ? a_s1 : '0;
               b_s2 <= access ? b_s1 : '0;
            end
         end

         assign aQ = a_s2;
         assign bQ = b_s2;
      end else begin : g_no_oreg
         assign aQ = a_s1;
         assign bQ = b_s1;
      end
   endgenerate

   assign BUSY = (state == CLEAR);
   assign COL  = col_pulse;

endmodule

`default_nettype wire
